rr_grant_arbiter: RTL and testbench



---
 rtl/rr_arb_pkg.sv | 12 +
 rtl/priority_encoder.sv | 28 ++
 rtl/rr_grant_arbiter.sv | 169 ++++++++++++++++
 tb/tb_rr_grant_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin grant arbiter: FSM encodings and
// hold-counter width.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int HOLD_CNT_WIDTH = 16;

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder. RIGHT_TO_LEFT_PRIORITY=0 picks the lowest
// set index, 1 picks the highest. vld is low when no bit is set (idx=0).
module priority_encoder #(
    parameter int WIDTH                  = 8,
    parameter int IDX_WIDTH              = $clog2(WIDTH),
    parameter bit RIGHT_TO_LEFT_PRIORITY = 1'b0
) (
    input  logic [WIDTH-1:0]     req_vec,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 vld
);

    always_comb begin
        idx = '0;
        vld = |req_vec;
        if (!RIGHT_TO_LEFT_PRIORITY) begin
            // Scan downwards so the lowest set bit is the last assignment.
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req_vec[i]) idx = IDX_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req_vec[i]) idx = IDX_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter; the holder keeps the grant until it releases.
// Optional forced rotation after MAX_HOLD cycles: define RR_GRANT_ARBITER_HOLD_LIMIT_EN.
//
// state | meaning
// IDLE  | no grant active, waiting for any request
// GRANT | grant_idx owns the resource until its req drops (or hold limit)
module rr_grant_arbiter
    import rr_arb_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 3,
    parameter int NUM_REQ      = 2 ** OUTPUT_WIDTH,
    parameter int MAX_HOLD     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    output logic [NUM_REQ-1:0]      grant,
    output logic [OUTPUT_WIDTH-1:0] grant_idx,
    output logic                    grant_vld,
    output logic                    grant_revoked
);

    if (NUM_REQ != 2 ** OUTPUT_WIDTH) begin : g_bad_num_req
        $error("NUM_REQ must equal 2**OUTPUT_WIDTH");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..65535");
    end

    arb_state_t                state, state_nxt;
    logic [NUM_REQ-1:0]        grant_nxt;
    logic [OUTPUT_WIDTH-1:0]   grant_idx_nxt;
    logic                      grant_vld_nxt;
    logic [OUTPUT_WIDTH-1:0]   last_idx, last_idx_nxt;

    logic [NUM_REQ-1:0]        req_mask;
    logic [NUM_REQ-1:0]        arb_req;
    logic [NUM_REQ-1:0]        arb_req_masked;
    logic [OUTPUT_WIDTH-1:0]   masked_idx, unmasked_idx, win_idx;
    logic                      masked_vld, unmasked_vld;
    logic                      holder_release;
    logic                      hold_expire;

    // The current holder is removed from the candidates, which covers both a
    // normal release (its req is already low) and a forced hold-limit rotation.
    assign arb_req        = req & ~grant;
    assign arb_req_masked = arb_req & req_mask;

    always_comb begin
        req_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_mask[i] = (i > int'(last_idx));
        end
    end

    priority_encoder #(
        .WIDTH                  (NUM_REQ),
        .IDX_WIDTH              (OUTPUT_WIDTH),
        .RIGHT_TO_LEFT_PRIORITY (1'b0)
    ) u_pe_masked (
        .req_vec (arb_req_masked),
        .idx     (masked_idx),
        .vld     (masked_vld)
    );

    priority_encoder #(
        .WIDTH                  (NUM_REQ),
        .IDX_WIDTH              (OUTPUT_WIDTH),
        .RIGHT_TO_LEFT_PRIORITY (1'b0)
    ) u_pe_unmasked (
        .req_vec (arb_req),
        .idx     (unmasked_idx),
        .vld     (unmasked_vld)
    );

    assign win_idx        = masked_vld ? masked_idx : unmasked_idx;
    assign holder_release = ~req[grant_idx];

`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
    logic [HOLD_CNT_WIDTH-1:0] hold_cnt, hold_cnt_nxt;
    logic                      revoked_nxt;

    assign hold_expire = (hold_cnt == HOLD_CNT_WIDTH'(MAX_HOLD - 1)) && req[grant_idx];
`else
    assign hold_expire = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        grant_idx_nxt = grant_idx;
        grant_vld_nxt = grant_vld;
        last_idx_nxt  = last_idx;
`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
        hold_cnt_nxt  = hold_cnt;
        revoked_nxt   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (unmasked_vld) begin
                    state_nxt     = GRANT;
                    grant_nxt     = NUM_REQ'(1) << win_idx;
                    grant_idx_nxt = win_idx;
                    grant_vld_nxt = 1'b1;
                    last_idx_nxt  = win_idx;
`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
                    hold_cnt_nxt  = '0;
`endif
                end
            end
            GRANT: begin
                if (holder_release || hold_expire) begin
                    if (unmasked_vld) begin
                        grant_nxt     = NUM_REQ'(1) << win_idx;
                        grant_idx_nxt = win_idx;
                        last_idx_nxt  = win_idx;
`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
                        revoked_nxt   = hold_expire;
`endif
                    end else if (holder_release) begin
                        state_nxt     = IDLE;
                        grant_nxt     = '0;
                        grant_idx_nxt = '0;
                        grant_vld_nxt = 1'b0;
                    end
`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
                    hold_cnt_nxt = '0;
`endif
                end else begin
`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
                    hold_cnt_nxt = hold_cnt + 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            grant_vld <= 1'b0;
            last_idx  <= OUTPUT_WIDTH'(NUM_REQ - 1);
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            grant_idx <= grant_idx_nxt;
            grant_vld <= grant_vld_nxt;
            last_idx  <= last_idx_nxt;
        end
    end

`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt      <= '0;
            grant_revoked <= 1'b0;
        end else begin
            hold_cnt      <= hold_cnt_nxt;
            grant_revoked <= revoked_nxt;
        end
    end
`else
    assign grant_revoked = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (NUM_REQ=8) with hand-computed expectations.
// Hold-limit expectations follow RR_GRANT_ARBITER_HOLD_LIMIT_EN when defined.
module tb_rr_grant_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_vld;
    logic       grant_revoked;

    int checks   = 0;
    int failures = 0;

    rr_grant_arbiter #(
        .OUTPUT_WIDTH (3),
        .MAX_HOLD     (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .grant_vld     (grant_vld),
        .grant_revoked (grant_revoked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [2:0] idx);
        chk({tag, "_idx"}, 32'(grant_idx), 32'(idx));
        chk({tag, "_grant"}, 32'(grant), 32'(8'h01 << idx));
        chk({tag, "_vld"}, 32'(grant_vld), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_idx"}, 32'(grant_idx), 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_vld"}, 32'(grant_vld), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 8'h00;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_idx;
        logic       exp_rev;

        reset = 1'b1;
        req   = 8'h00;
        step();
        step();
        chk_idle("rst");
        chk("rst_revoked", 32'(grant_revoked), 32'd0);
        reset = 1'b0;

        // First grant: one-cycle latency, lowest index wins after reset.
        req = 8'b1000_0001;
        step();
        chk_grant("first", 3'd0);
        req = 8'h00;
        step();
        chk_idle("first_rel");

        // Full rotation with every holder dropping once, no bubbles.
        do_reset();
        req = 8'hFF;
        step();
        chk_grant("rot0", 3'd0);
        for (int k = 1; k <= 8; k++) begin
            req = 8'hFF & ~(8'h01 << ((k - 1) % 8));
            step();
            chk_grant($sformatf("rot%0d", k), 3'(k % 8));
        end

        // Wrap-around: after 6 held and released, mask is only bit 7.
        do_reset();
        req = 8'h40;
        step();
        chk_grant("wrap_g6", 3'd6);
        req = 8'h00;
        step();
        chk_idle("wrap_idle");
        req = 8'b0010_0100;
        step();
        chk_grant("wrap", 3'd2);
        req = 8'h00;
        step();
        chk_idle("wrap_rel");

        // Hold behaviour: req[3] held, req[1] pending for 40 cycles.
        req = 8'h08;
        step();
        chk_grant("hold_g3", 3'd3);
        req = 8'h0A;
        for (int c = 1; c <= 40; c++) begin
            step();
`ifdef RR_GRANT_ARBITER_HOLD_LIMIT_EN
            exp_idx = (((c / 16) % 2) == 1) ? 3'd1 : 3'd3;
            exp_rev = ((c % 16) == 0);
`else
            exp_idx = 3'd3;
            exp_rev = 1'b0;
`endif
            chk($sformatf("hold_idx_c%0d", c), 32'(grant_idx), 32'(exp_idx));
            chk($sformatf("hold_rev_c%0d", c), 32'(grant_revoked), 32'(exp_rev));
        end
        req = 8'h00;
        step();
        chk_idle("hold_rel");

        // Asynchronous reset mid-grant clears outputs before the next edge.
        req = 8'h10;
        step();
        chk_grant("arst_g4", 3'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_vld", 32'(grant_vld), 32'd0);
        chk("arst_idx", 32'(grant_idx), 32'd0);
        #1;
        reset = 1'b0;
        req = 8'h80;
        step();
        chk_grant("arst_g7", 3'd7);

        // Single requester: release for one cycle, then regrant.
        req = 8'h10;
        step();
        chk_grant("single_g4", 3'd4);
        req = 8'h00;
        step();
        chk_idle("single_idle");
        req = 8'h10;
        step();
        chk_grant("single_regrant", 3'd4);
        chk("single_revoked", 32'(grant_revoked), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
